// File: rtl/trace_pkg.sv
// trace_pkg: shared trace entry layout and wrap-mode encodings for the execution trace buffer
package trace_pkg;
   localparam int PC_W = 16;
   localparam int STATE_W = 2;
   localparam int INSTR_W = 32;
   localparam int TS_W = 32;
   localparam int WRAP_STOP = 0;
   localparam int WRAP_OVERWRITE = 1;
   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [STATE_W-1:0] state;
      logic [INSTR_W-1:0] instr;
      logic [TS_W-1:0]    stamp;
   } trace_entry_t;
endpackage

// File: rtl/trace_ring_mem.sv
// trace_ring_mem: DEPTH x WIDTH register array, one write port and one combinational read port
module trace_ring_mem #(
   parameter int WIDTH = 82,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clock)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer: records PC/state changes with a cycle stamp into a circular FWFT buffer
module exec_trace_buffer
   import trace_pkg::*;
#(
   parameter int PC_WIDTH    = PC_W,
   parameter int STATE_WIDTH = STATE_W,
   parameter int INSTR_WIDTH = INSTR_W,
   parameter int TS_WIDTH    = TS_W,
   parameter int DEPTH       = 16,
   parameter int WRAP_MODE   = WRAP_STOP
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       clear,
   input  logic [PC_WIDTH-1:0]        pc_i,
   input  logic [STATE_WIDTH-1:0]     state_i,
   input  logic [INSTR_WIDTH-1:0]     instr_i,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [PC_WIDTH-1:0]        rd_pc,
   output logic [STATE_WIDTH-1:0]     rd_state,
   output logic [INSTR_WIDTH-1:0]     rd_instr,
   output logic [TS_WIDTH-1:0]        rd_stamp,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       overflow,
   output logic [15:0]                drop_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = PC_WIDTH + STATE_WIDTH + INSTR_WIDTH + TS_WIDTH;
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [TS_WIDTH-1:0]    stamp;
   logic [PC_WIDTH-1:0]    last_pc;
   logic [STATE_WIDTH-1:0] last_state;
   logic                   primed, ev, pop, push, lost, ovw, we;
   logic [EW-1:0]          rdata;
   assign rd_valid = count != '0;
   assign full = count == CW'(DEPTH);
   assign {rd_pc, rd_state, rd_instr, rd_stamp} = rdata;
   // a full buffer still accepts an event when the same cycle pops, so nothing is lost
   always_comb begin
      ev   = enable && (!primed || pc_i != last_pc || state_i != last_state);
      pop  = rd_valid && rd_ready;
      push = ev && (!full || pop);
      lost = ev && full && !pop;
      ovw  = lost && (WRAP_MODE == WRAP_OVERWRITE);
      we   = reset && !clear && (push || ovw);
   end
   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         stamp      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
         primed     <= 1'b0;
         last_pc    <= '0;
         last_state <= '0;
      end else begin
         stamp <= stamp + TS_WIDTH'(1);
         if (ev) begin
            primed     <= 1'b1;
            last_pc    <= pc_i;
            last_state <= state_i;
         end
         if (push || ovw) wr_ptr <= wr_ptr + AW'(1);
         if (pop || ovw) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (lost) begin
            overflow   <= 1'b1;
            drop_count <= drop_count + 16'(drop_count != 16'hFFFF);
         end
      end
   end
   trace_ring_mem #(.WIDTH(EW), .DEPTH(DEPTH)) u_mem (
      .clock(clock),
      .we(we),
      .waddr(wr_ptr),
      .wdata({pc_i, state_i, instr_i, stamp}),
      .raddr(rd_ptr),
      .rdata(rdata)
   );
endmodule
